pipe_arbiter: RTL and testbench

Shares the team's fixed-latency two-stage arithmetic datapath between NUM_REQ requesters. It accepts one operand per cycle under round-robin arbitration and drives it into the datapath. An ID tag pipeline matched to the datapath latency tracks each operand, and the controller returns each tagged result through a credit-protected response FIFO with valid/ready backpressure. It sits between the requester fabric and the datapath instance; the datapath itself has no valid or stall, so this block owns all flow control.

---
 rtl/pipe_arb_pkg.sv | 24 ++
 rtl/rr_arbiter.sv | 49 ++++
 rtl/pipe_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_pipe_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_arb_pkg.sv
// ============================================================================
// pipe_arb_pkg : shared types, default constants and helpers for pipe_arbiter
// Revision     : 1.0
// ============================================================================
`default_nettype none

package pipe_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } pipe_arb_state_t;

    localparam int PIPE_ARB_NUM_REQ = 4;
    localparam int PIPE_ARB_DP_LAT  = 2;

    function automatic int pipe_arb_idw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// rr_arbiter : combinational round-robin pick of the first request at or
//              after rr_ptr, wrapping at NUM_REQ
// Revision   : 1.0
// ============================================================================
`default_nettype none

module rr_arbiter
    import pipe_arb_pkg::*;
#(
    parameter  int NUM_REQ = PIPE_ARB_NUM_REQ,
    localparam int IDW     = pipe_arb_idw(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     rr_ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDW-1:0]     grant_id
);

    localparam logic [IDW:0] N_WIDE = (IDW+1)'(NUM_REQ);

    logic [IDW:0]   sum;
    logic [IDW-1:0] idx;
    logic           found;

    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        sum      = '0;
        idx      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, rr_ptr} + (IDW+1)'(k);
            if (sum >= N_WIDE) begin
                sum = sum - N_WIDE;
            end
            idx = sum[IDW-1:0];
            if (en && !found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_id   = idx;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/pipe_arbiter.sv
// ============================================================================
// pipe_arbiter : round-robin issue into a fixed-latency datapath with a tag
//                pipeline and credit-protected response FIFO.
//                Optional statistics counters: define PIPE_ARB_STATS_EN.
// Revision     : 1.0
// ============================================================================
`default_nettype none

module pipe_arbiter
    import pipe_arb_pkg::*;
#(
    parameter  int NUM_REQ   = PIPE_ARB_NUM_REQ,
    parameter  int W_IN      = 10,
    parameter  int W_OUT     = 20,
    parameter  int DP_LAT    = PIPE_ARB_DP_LAT,
    parameter  int RSP_DEPTH = 4,
    localparam int IDW       = pipe_arb_idw(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*W_IN-1:0] req_data,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic [W_IN-1:0]         dp_in,
    input  logic [W_OUT-1:0]        dp_out,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [IDW-1:0]          rsp_id,
    output logic [W_OUT-1:0]        rsp_data,
    output logic                    busy,
    output logic                    idle
`ifdef PIPE_ARB_STATS_EN
    ,
    output logic [31:0]             issue_count,
    output logic [31:0]             stall_count
`endif
);

    localparam int AW = $clog2(RSP_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] CRED_MAX = CW'(RSP_DEPTH);

    pipe_arb_state_t state, state_nxt;
    logic            run_active;

    logic [CW-1:0]      credits;
    logic [IDW-1:0]     rr_ptr;
    logic [NUM_REQ-1:0] grant;
    logic [IDW-1:0]     grant_id;
    logic               arb_en;
    logic               issue;
    logic               push;
    logic               pop;

    logic               tag_valid [DP_LAT];
    logic [IDW-1:0]     tag_id    [DP_LAT];

    logic [IDW+W_OUT-1:0] fifo_mem [RSP_DEPTH];
    logic [AW:0]          wr_ptr;
    logic [AW:0]          rd_ptr;
    logic [IDW+W_OUT-1:0] head;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (en) state_nxt = RUN;
            RUN:     if (!en) state_nxt = busy ? DRAIN : IDLE;
            DRAIN:   if (credits == CRED_MAX) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        idle       = (state == IDLE);
        run_active = (state == RUN);
    end

    // ---------------- Issue ----------------
    assign arb_en = run_active && en && (credits != '0);

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req      (req_valid),
        .rr_ptr   (rr_ptr),
        .en       (arb_en),
        .grant    (grant),
        .grant_id (grant_id)
    );

    assign issue     = |grant;
    assign req_ready = grant;
    assign dp_in     = issue ? req_data[int'(grant_id)*W_IN +: W_IN] : '0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_ptr <= '0;
        end else if (issue) begin
            rr_ptr <= (grant_id == IDW'(NUM_REQ-1)) ? '0 : grant_id + IDW'(1);
        end
    end

    // Tags shift every cycle so the last stage lines up with dp_out.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DP_LAT; i++) begin
                tag_valid[i] <= 1'b0;
                tag_id[i]    <= '0;
            end
        end else begin
            tag_valid[0] <= issue;
            tag_id[0]    <= grant_id;
            for (int i = 1; i < DP_LAT; i++) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_id[i]    <= tag_id[i-1];
            end
        end
    end

    assign push = tag_valid[DP_LAT-1];

    // ---------------- Credits ----------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            credits <= CRED_MAX;
        end else if (issue && !pop) begin
            credits <= credits - CW'(1);
        end else if (!issue && pop) begin
            credits <= credits + CW'(1);
        end
    end

    assign busy = (credits != CRED_MAX);

    // ---------------- Response FIFO ----------------
    // Credits bound occupancy, so a push never meets a full FIFO.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr[AW-1:0]] <= {tag_id[DP_LAT-1], dp_out};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    assign head      = fifo_mem[rd_ptr[AW-1:0]];
    assign rsp_valid = (wr_ptr != rd_ptr);
    assign pop       = rsp_valid && rsp_ready;
    assign rsp_id    = rsp_valid ? head[IDW+W_OUT-1:W_OUT] : '0;
    assign rsp_data  = rsp_valid ? head[W_OUT-1:0] : '0;

`ifdef PIPE_ARB_STATS_EN
    logic stall;
    assign stall = run_active && (|req_valid) && (credits == '0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            issue_count <= '0;
            stall_count <= '0;
        end else begin
            if (issue && (issue_count != '1)) issue_count <= issue_count + 32'd1;
            if (stall && (stall_count != '1)) stall_count <= stall_count + 32'd1;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_arbiter.sv
// ============================================================================
// tb_pipe_arbiter : directed stimulus with queue scoreboard for pipe_arbiter
// Revision        : 1.0
// ============================================================================
`default_nettype none

module tb_pipe_arbiter;
    import pipe_arb_pkg::*;

    localparam int NUM_REQ   = 4;
    localparam int W_IN      = 10;
    localparam int W_OUT     = 20;
    localparam int DP_LAT    = 2;
    localparam int RSP_DEPTH = 4;
    localparam int IDW       = pipe_arb_idw(NUM_REQ);

    logic                    clk = 1'b0;
    logic                    reset = 1'b0;
    logic                    en = 1'b0;
    logic                    rsp_ready = 1'b0;
    logic [NUM_REQ-1:0]      req_valid = '0;
    logic [NUM_REQ*W_IN-1:0] req_data = '0;
    logic [NUM_REQ-1:0]      req_ready;
    logic [W_IN-1:0]         dp_in;
    logic [W_OUT-1:0]        dp_out;
    logic                    rsp_valid;
    logic [IDW-1:0]          rsp_id;
    logic [W_OUT-1:0]        rsp_data;
    logic                    busy;
    logic                    idle;
`ifdef PIPE_ARB_STATS_EN
    logic [31:0]             issue_count;
    logic [31:0]             stall_count;
`endif

    int errors = 0;
    int checks = 0;
    logic [IDW+W_OUT-1:0] exp_q [$];

    logic [W_OUT-1:0]     dp_s1, dp_s2;
    logic                 held = 1'b0;
    logic [IDW+W_OUT-1:0] held_val, got, exp_e;

    always #5 clk = ~clk;

    pipe_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .W_IN      (W_IN),
        .W_OUT     (W_OUT),
        .DP_LAT    (DP_LAT),
        .RSP_DEPTH (RSP_DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .dp_in     (dp_in),
        .dp_out    (dp_out),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .idle      (idle)
`ifdef PIPE_ARB_STATS_EN
        ,
        .issue_count (issue_count),
        .stall_count (stall_count)
`endif
    );

    // Two-stage datapath model: result = operand + 110.
    always_ff @(posedge clk) begin
        if (!reset) begin
            dp_s1 <= '0;
            dp_s2 <= '0;
        end else begin
            dp_s1 <= W_OUT'(dp_in) + W_OUT'(110);
            dp_s2 <= dp_s1;
        end
    end
    assign dp_out = dp_s2;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic push_exp(input logic [IDW-1:0] id, input logic [W_OUT-1:0] data);
        exp_q.push_back({id, data});
    endtask

    task automatic set_data(input int r, input int val);
        req_data[r*W_IN +: W_IN] = W_IN'(val);
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        en        = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        exp_q.delete();
        cyc();
        cyc();
        reset = 1'b1;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 30; i++) begin
            cyc();
            #1;
            if (idle) break;
        end
        check(name, idle, 1);
        check({name, "_busy"}, busy, 0);
        check({name, "_all_rsp"}, exp_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, req_ready, 0);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_rsp_id"},    rsp_id, 0);
        check({tag, "_rsp_data"},  rsp_data, 0);
        check({tag, "_dp_in"},     dp_in, 0);
        check({tag, "_busy"},      busy, 0);
        check({tag, "_idle"},      idle, 1);
    endtask

    // Monitor: pops expectations on every response handshake and checks hold.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!reset) begin
                held = 1'b0;
            end else begin
                got = {rsp_id, rsp_data};
                if (held) begin
                    check("rsp_hold_valid", rsp_valid, 1);
                    check("rsp_hold_value", got, held_val);
                end
                if (rsp_valid && rsp_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_rsp: got id=%0d data=%0d, expected no response",
                                 rsp_id, rsp_data);
                    end else begin
                        exp_e = exp_q.pop_front();
                        check("rsp_id", rsp_id, exp_e[IDW+W_OUT-1:W_OUT]);
                        check("rsp_data", rsp_data, exp_e[W_OUT-1:0]);
                    end
                end
                held     = rsp_valid && !rsp_ready;
                held_val = got;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NUM_REQ-1:0] eg;

        // Reset values, with requests and enable asserted during reset.
        reset     = 1'b0;
        en        = 1'b1;
        req_valid = '1;
        repeat (3) cyc();
        #1;
        check_reset_outputs("rst");

        // Single request from requester 2.
        do_reset();
        rsp_ready = 1'b1;
        en        = 1'b1;
        cyc();
        set_data(2, 5);
        req_valid = 4'b0100;
        #1;
        check("t1_grant", req_ready, 4'b0100);
        check("t1_dp_in", dp_in, 5);
        check("t1_not_idle", idle, 0);
        push_exp(2'd2, 20'd115);
        cyc();
        req_valid = '0;
        en        = 1'b0;
        #1;
        check("t1_dp_in_idle", dp_in, 0);
        cyc();
        #1;
        check("t1_rsp_early", rsp_valid, 0);
        cyc();
        #1;
        check("t1_rsp_latency", rsp_valid, 1);
        wait_idle("t1_idle");

        // All four requesters continuously valid.
        do_reset();
        rsp_ready = 1'b1;
        en        = 1'b1;
        for (int r = 0; r < NUM_REQ; r++) set_data(r, 100 * (r + 1));
        cyc();
        req_valid = '1;
        for (int k = 0; k < 8; k++) begin
            #1;
            eg = NUM_REQ'(1 << (k % 4));
            check("t2_grant", req_ready, eg);
            push_exp(IDW'(k % 4), W_OUT'(100 * (k % 4 + 1) + 110));
            cyc();
        end
        req_valid = '0;
        en        = 1'b0;
        wait_idle("t2_idle");

        // Backpressure: requester 0 streaming with rsp_ready low.
        do_reset();
        rsp_ready = 1'b0;
        en        = 1'b1;
        cyc();
        req_valid = 4'b0001;
        for (int k = 1; k <= 4; k++) begin
            set_data(0, k);
            #1;
            check("t3_grant", req_ready, 4'b0001);
            push_exp(2'd0, W_OUT'(k + 110));
            cyc();
        end
        set_data(0, 50);
        for (int k = 5; k <= 8; k++) begin
            #1;
            check("t3_no_credit", req_ready, 0);
            cyc();
        end
        #1;
`ifdef PIPE_ARB_STATS_EN
        check("t3_issue_count", issue_count, 4);
        check("t3_stall_count", stall_count, 4);
`endif
        check("t3_fifo_full_valid", rsp_valid, 1);
        rsp_ready = 1'b1;
        #1;
        check("t3_no_credit_yet", req_ready, 0);
        cyc();
        #1;
        check("t3_freed_grant0", req_ready, 4'b0001);
        push_exp(2'd0, 20'd160);
        cyc();
        set_data(0, 60);
        #1;
        check("t3_freed_grant1", req_ready, 4'b0001);
        push_exp(2'd0, 20'd170);
        cyc();
        req_valid = '0;
        en        = 1'b0;
        wait_idle("t3_idle");

        // Drop enable with three operands in flight.
        do_reset();
        rsp_ready = 1'b1;
        en        = 1'b1;
        for (int r = 0; r < NUM_REQ; r++) set_data(r, 100 * (r + 1));
        cyc();
        req_valid = '1;
        for (int k = 0; k < 3; k++) begin
            #1;
            eg = NUM_REQ'(1 << k);
            check("t5_grant", req_ready, eg);
            push_exp(IDW'(k), W_OUT'(100 * (k + 1) + 110));
            cyc();
        end
        en = 1'b0;
        #1;
        check("t5_no_grant_en0", req_ready, 0);
        cyc();
        en = 1'b1;
        #1;
        check("t5_drain_no_grant", req_ready, 0);
        check("t5_drain_not_idle", idle, 0);
        cyc();
        en        = 1'b0;
        req_valid = '0;
        wait_idle("t5_idle");

        // Reset with the FIFO half full and one operand in flight.
        do_reset();
        rsp_ready = 1'b0;
        en        = 1'b1;
        cyc();
        req_valid = 4'b1000;
        for (int k = 0; k < 3; k++) begin
            set_data(3, 20 + k);
            #1;
            check("t6_grant", req_ready, 4'b1000);
            cyc();
        end
        req_valid = '0;
        cyc();
        #1;
        check("t6_half_valid", rsp_valid, 1);
        check("t6_half_id", rsp_id, 3);
        check("t6_half_data", rsp_data, 130);
        reset     = 1'b0;
        req_valid = 4'b1000;
        exp_q.delete();
        cyc();
        #1;
        check_reset_outputs("t6_rst");
        reset     = 1'b1;
        en        = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (8) cyc();
        #1;
        check("t6_no_stale", rsp_valid, 0);
        check("t6_idle", idle, 1);
        check("t6_busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
